sqrt_pipe: RTL and testbench
============================

SQRT_PIPE -- requirements
Module: sqrt_pipe

Interface
REQ-001 Parameter IN_W, default 31, radicand input width in bits.
REQ-002 Parameter OUT_W, default 17, root output width; SHALL satisfy 2*OUT_W >= IN_W, otherwise elaboration fails.
REQ-003 Parameter TAG_W, default 4, width of the sideband tag (channel ID) carried alongside each sample.
REQ-004 Derived constant PAD = 2*OUT_W - IN_W, with default value 3.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  input sample present.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 e  input  IN_W  unsigned radicand.
REQ-010 in_tag  input  TAG_W  sideband tag for the sample.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 f  output  OUT_W  unsigned root.
REQ-014 out_tag  output  TAG_W  tag of the sample in f.
REQ-015 out_zero  output  1  asserted when e of the result sample was 0.

Function
REQ-016 Arithmetic: f SHALL equal floor(sqrt(e * 2^PAD)) exactly for all e, with no rounding and no saturation.
REQ-017 Datapath: OUT_W-stage non-restoring (or restoring) digit-recurrence pipeline, one root bit per stage, MSB first.
- Each stage registers partial root, remainder, tag, zero flag and a valid bit.
REQ-018 Transfer rules:
- An input is accepted on a cycle with in_valid && in_ready.
- An output is consumed on a cycle with out_valid && out_ready.
REQ-019 Stall: stall = out_valid && !out_ready.
- While stall=1, every pipeline register holds its value.
- in_ready = !stall, purely combinational from out_valid/out_ready; no dependence on in_valid.
REQ-020 When not stalled, all stages advance one position per cycle.
- Stage 0 loads the accepted sample, or a bubble (valid=0) when in_valid=0.
REQ-021 Latency: a sample accepted at edge N with no stalls SHALL present out_valid=1 with its result after edge N+OUT_W.
- Each stall cycle adds exactly one cycle of latency.
REQ-022 Throughput: one sample per cycle with out_ready held high; bubbles propagate unchanged.
REQ-023 Ordering: results SHALL emerge in acceptance order.
- out_tag and out_zero stay aligned with their f; no sample is dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 Outputs f, out_tag and out_zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 When out_valid=0, the values of f, out_tag and out_zero are don't-care for the consumer, but SHALL be the registered last-stage values (no X after reset).
REQ-026 Simultaneous events:
- If the output is consumed and a new input is accepted in the same cycle, both occur and the pipeline advances.
- in_valid asserted during a stall is not accepted; the source holds it.
REQ-027 Maximum input e = 2^IN_W - 1 SHALL yield f = 2^OUT_W - 1 at defaults, with no wrap in the remainder.
- The remainder register is OUT_W+2 bits wide.

Reset
REQ-028 On rst=0, all valid bits, partial roots, remainders, tags and zero flags SHALL clear to 0 asynchronously.
- Outputs: out_valid=0, f=0, out_tag=0, out_zero=0; in_ready=1.
REQ-029 Reset mid-operation SHALL discard every in-flight sample; none emerges after reset release.
REQ-030 First acceptance is possible on the first rising edge with rst=1.

Verification
REQ-031 Defaults, out_ready=1, single samples:
- e=0 -> f=0, out_zero=1.
- e=1 -> f=2.
- e=2 -> f=4.
- e=0x20000000 -> f=0x10000.
- e=0x7FFFFFFF -> f=0x1FFFF.
- Each result appears exactly 17 cycles after acceptance.
REQ-032 Back-to-back: 100 random e with tags 0..15 cycling, out_ready=1.
- One result per cycle starting cycle 17; tags in order; every f matches floor(sqrt(e*8)).
REQ-033 Backpressure: out_ready random 50%, in_valid random 70%, 10000 samples.
- No loss or duplication; order preserved.
- f/out_tag stable during every stall cycle.
- in_ready == !(out_valid && !out_ready) every cycle.
REQ-034 Reset mid-stream: assert rst=0 for 1 cycle with 10 samples in flight.
- out_valid=0 immediately; no stale result afterward.
- Next accepted sample, e=2, returns f=4 after 17 cycles.
REQ-035 Parameter sweep: (IN_W,OUT_W) = (8,4), (16,8), (31,17), (32,20).
- Exhaustive for IN_W=8 and random for the others, checked against floor(sqrt(e*2^PAD)); latency = OUT_W.

Source files
------------

// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined integer square root, f = floor(sqrt(e * 2^PAD)).
// A capture stage (stage 0) registers the accepted sample. OUT_W restoring
// digit-recurrence stages follow, each resolving one root bit, MSB first.
// Sample-to-result latency is therefore OUT_W cycles.
//
// Handshake: a sample transfers on in_valid && in_ready. A result transfers
// on out_valid && out_ready. The only stall source is a result that is
// presented but not taken (out_valid && !out_ready). A stall freezes every
// stage at once, and in_ready is the inverse of that stall term.
module sqrt_pipe #(
  parameter int IN_W  = 31,
  parameter int OUT_W = 17,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  e,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] f,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int PAD   = 2*OUT_W - IN_W;  // radicand pre-scale, in bits
  localparam int RAD_W = 2*OUT_W;         // scaled radicand width
  localparam int REM_W = OUT_W + 2;       // remainder never exceeds 2*root
  localparam int NST   = OUT_W;           // index of the last (output) stage

  if ((2*OUT_W < IN_W) || (OUT_W < 2)) begin : g_param_check
    $error("sqrt_pipe: parameters need 2*OUT_W >= IN_W and OUT_W >= 2");
  end

  logic             w_stall;
  logic [RAD_W-1:0] w_rad_in;
  logic             w_zero_in;

  // Per-stage register outputs, gathered for the neighbouring stage.
  logic             w_vld  [0:NST];
  logic [OUT_W-1:0] w_root [0:NST];
  logic [REM_W-1:0] w_rem  [0:NST];
  logic [RAD_W-1:0] w_rad  [0:NST];
  logic [TAG_W-1:0] w_tag  [0:NST];
  logic             w_zero [0:NST];

  assign w_stall   = w_vld[NST] && !out_ready;
  assign in_ready  = !w_stall;
  assign w_rad_in  = RAD_W'(e) << PAD;
  assign w_zero_in = (e == '0);

  for (genvar k = 0; k <= NST; k++) begin : g_stage
    logic             r_vld;
    logic [OUT_W-1:0] r_root;
    logic [REM_W-1:0] r_rem;
    logic [RAD_W-1:0] r_rad;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;

    logic             w_nx_vld;
    logic [OUT_W-1:0] w_nx_root;
    logic [REM_W-1:0] w_nx_rem;
    logic [RAD_W-1:0] w_nx_rad;
    logic [TAG_W-1:0] w_nx_tag;
    logic             w_nx_zero;

    if (k == 0) begin : g_load
      // Capture stage: empty root/remainder, the scaled radicand waits here.
      assign w_nx_vld  = in_valid;
      assign w_nx_root = '0;
      assign w_nx_rem  = '0;
      assign w_nx_rad  = w_rad_in;
      assign w_nx_tag  = in_tag;
      assign w_nx_zero = w_zero_in;
    end else begin : g_iter
      // The remainder is widened by two bits here: it absorbs the next
      // radicand bit pair before the trial subtraction.
      logic [REM_W+1:0] w_sh;
      logic [REM_W+1:0] w_trial;
      logic [REM_W+1:0] w_diff;
      logic             w_ge;
      logic             w_unused_top;

      assign w_sh    = {w_rem[k-1], w_rad[k-1][RAD_W-1 -: 2]};
      assign w_trial = {2'b00, w_root[k-1], 2'b01};
      assign w_ge    = (w_sh >= w_trial);
      assign w_diff  = w_sh - w_trial;

      // Root holds only k-1 bits on entry, so its MSB is always zero.
      // The difference also fits back into REM_W bits once w_ge is set.
      assign w_unused_top = w_root[k-1][OUT_W-1] ^ (^w_diff[REM_W+1:REM_W]);

      assign w_nx_vld  = w_vld[k-1];
      assign w_nx_root = {w_root[k-1][OUT_W-2:0], w_ge};
      assign w_nx_rem  = w_ge ? w_diff[REM_W-1:0] : w_sh[REM_W-1:0];
      assign w_nx_rad  = {w_rad[k-1][RAD_W-3:0], 2'b00};
      assign w_nx_tag  = w_tag[k-1];
      assign w_nx_zero = w_zero[k-1];
    end

    // Stage register: cleared by reset, frozen while the output is stalled.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_vld  <= 1'b0;
        r_root <= '0;
        r_rem  <= '0;
        r_rad  <= '0;
        r_tag  <= '0;
        r_zero <= 1'b0;
      end else if (!w_stall) begin
        r_vld  <= w_nx_vld;
        r_root <= w_nx_root;
        r_rem  <= w_nx_rem;
        r_rad  <= w_nx_rad;
        r_tag  <= w_nx_tag;
        r_zero <= w_nx_zero;
      end
    end

    assign w_vld[k]  = r_vld;
    assign w_root[k] = r_root;
    assign w_rem[k]  = r_rem;
    assign w_rad[k]  = r_rad;
    assign w_tag[k]  = r_tag;
    assign w_zero[k] = r_zero;
  end

  // The final remainder and the fully shifted-out radicand are not needed.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_rem[NST], w_rad[NST]};

  assign out_valid = w_vld[NST];
  assign f         = w_root[NST];
  assign out_tag   = w_tag[NST];
  assign out_zero  = w_zero[NST];

endmodule

// File: tb/tb_sqrt_pipe.sv
// tb_sqrt_pipe: self-checking bench for sqrt_pipe.
// Expected results are queued when a sample is driven and accepted. They are
// popped and compared when the DUT hands a result over.
// Valid/ready: a transfer happens on a rising edge where valid && ready. The
// bench drives on the falling edge and samples DUT outputs there too.
module tb_sqrt_pipe;

  // ---------------- clock / reset ----------------
  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [30:0] e         = '0;
  logic [3:0]  in_tag    = '0;
  logic        in_ready;
  logic        out_valid;
  logic [16:0] f;
  logic [3:0]  out_tag;
  logic        out_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .e(e),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  // Parameter-sweep instances: always ready downstream, tag unused.
  logic        sw_rdy = 1'b1;
  logic [3:0]  sw_tag = 4'd0;
  logic        s8_v = 1'b0, s16_v = 1'b0, s32_v = 1'b0;
  logic [7:0]  s8_e = '0;
  logic [15:0] s16_e = '0;
  logic [31:0] s32_e = '0;
  logic        s8_ir, s8_ov, s8_z, s16_ir, s16_ov, s16_z, s32_ir, s32_ov, s32_z;
  logic [3:0]  s8_f, s8_t, s16_t, s32_t;
  logic [7:0]  s16_f;
  logic [19:0] s32_f;

  sqrt_pipe #(.IN_W(8), .OUT_W(4), .TAG_W(4)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(s8_v), .in_ready(s8_ir), .e(s8_e),
    .in_tag(sw_tag), .out_valid(s8_ov), .out_ready(sw_rdy), .f(s8_f),
    .out_tag(s8_t), .out_zero(s8_z)
  );
  sqrt_pipe #(.IN_W(16), .OUT_W(8), .TAG_W(4)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(s16_v), .in_ready(s16_ir), .e(s16_e),
    .in_tag(sw_tag), .out_valid(s16_ov), .out_ready(sw_rdy), .f(s16_f),
    .out_tag(s16_t), .out_zero(s16_z)
  );
  sqrt_pipe #(.IN_W(32), .OUT_W(20), .TAG_W(4)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(s32_v), .in_ready(s32_ir), .e(s32_e),
    .in_tag(sw_tag), .out_valid(s32_ov), .out_ready(sw_rdy), .f(s32_f),
    .out_tag(s32_t), .out_zero(s32_z)
  );

  // ---------------- reference model ----------------
  // Bit-by-bit search on the square: largest r with r*r <= x.
  function automatic logic [31:0] isqrt(input logic [63:0] x);
    logic [63:0] r;
    logic [63:0] c;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      c = r | (64'd1 << b);
      if (c * c <= x) r = c;
    end
    return r[31:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q  [$];
  logic [3:0]  tag_q  [$];
  logic        zero_q [$];
  int          acc_q  [$];

  logic        sb_popped, sb_unexp, sb_rdy_exp, sb_held_chk, prev_stall = 1'b0;
  logic [16:0] sb_exp_f;
  logic [3:0]  sb_exp_tag;
  logic        sb_exp_zero;
  int          sb_lat;
  logic [22:0] sb_held_val = '0, sb_now_val;

  // ---------------- driver ----------------
  // One cycle: apply inputs on the falling edge. If the current result will
  // be taken at the next rising edge, pop it. If the sample will be
  // accepted, push its expectation.
  task automatic drive_cycle(input logic iv, input logic [30:0] ev,
                             input logic [3:0] tv, input logic ordy);
    logic [31:0] r;
    @(negedge clk);
    sb_held_chk = prev_stall;
    sb_now_val  = {out_valid, f, out_tag, out_zero};
    in_valid  = iv;
    e         = ev;
    in_tag    = tv;
    out_ready = ordy;
    #1;
    sb_rdy_exp = !(out_valid && !ordy);
    sb_popped  = 1'b0;
    sb_unexp   = 1'b0;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) sb_unexp = 1'b1;
      else begin
        sb_exp_f    = exp_q.pop_front();
        sb_exp_tag  = tag_q.pop_front();
        sb_exp_zero = zero_q.pop_front();
        sb_lat      = cyc - acc_q.pop_front();
        sb_popped   = 1'b1;
      end
    end
    if (iv && sb_rdy_exp) begin
      r = isqrt({33'd0, ev} << 3);
      exp_q.push_back(r[16:0]);
      tag_q.push_back(tv);
      zero_q.push_back(ev == '0);
      acc_q.push_back(cyc + 1);
    end
    prev_stall  = out_valid && !ordy;
    sb_held_val = {out_valid, f, out_tag, out_zero};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (f !== 17'd0) begin n_fail++; $display("FAIL reset_f got=%h exp=0", f); end
    n_tests++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    n_tests++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    // Release just after a rising edge so the next edge is the first one
    // with reset high. The next drive puts a sample on that edge.
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [30:0] vals [5];
    logic [16:0] exps [5];
    logic got;
    vals = '{31'd0, 31'd1, 31'd2, 31'h20000000, 31'h7FFFFFFF};
    exps = '{17'd0, 17'd2, 17'd4, 17'h10000, 17'h1FFFF};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, vals[i], 4'(i + 3), 1'b1);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready[%0d] got=%b exp=1", i, in_ready); end
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        drive_cycle(1'b0, 31'd0, 4'd0, 1'b1);
        if (sb_unexp) begin n_tests++; n_fail++; $display("FAIL dir_unexpected[%0d] f=%h", i, f); end
        if (sb_popped) begin
          got = 1'b1;
          n_tests++; if (f !== exps[i]) begin n_fail++; $display("FAIL dir_f[%0d] got=%h exp=%h", i, f, exps[i]); end
          n_tests++; if (out_zero !== (i == 0)) begin n_fail++; $display("FAIL dir_zero[%0d] got=%b exp=%b", i, out_zero, (i == 0)); end
          n_tests++; if (out_tag !== 4'(i + 3)) begin n_fail++; $display("FAIL dir_tag[%0d] got=%h exp=%h", i, out_tag, 4'(i + 3)); end
          n_tests++; if (sb_lat !== 17) begin n_fail++; $display("FAIL dir_latency[%0d] got=%0d exp=17", i, sb_lat); end
        end
      end
      if (!got) begin n_tests++; n_fail++; $display("FAIL dir_timeout[%0d] got=no_result exp=result", i); end
    end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    logic [30:0] ev;
    for (int i = 0; i < 140; i++) begin
      ev = (i % 7 == 0) ? 31'd0 : 31'($urandom());
      drive_cycle(i < 100, ev, 4'(i % 16), 1'b1);
      if (sb_unexp) begin n_tests++; n_fail++; $display("FAIL b2b_unexpected cyc=%0d f=%h", cyc, f); end
      if (sb_popped) begin
        pops++;
        n_tests++;
        if ({f, out_tag, out_zero} !== {sb_exp_f, sb_exp_tag, sb_exp_zero}) begin
          n_fail++; $display("FAIL b2b_result got=%h/%h/%b exp=%h/%h/%b", f, out_tag, out_zero, sb_exp_f, sb_exp_tag, sb_exp_zero);
        end
        n_tests++; if (sb_lat !== 17) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=17", sb_lat); end
      end
    end
    n_tests++; if (pops !== 100) begin n_fail++; $display("FAIL b2b_count got=%0d exp=100", pops); end
  endtask

  task automatic test_backpressure();
    int n_acc = 0, pops = 0, budget = 0;
    logic pend = 1'b0, ordy;
    logic [30:0] cur_e = '0;
    logic [3:0]  cur_tag = '0, tag_ctr = '0;
    while ((n_acc < 10000 || exp_q.size() != 0) && budget < 80000) begin
      budget++;
      if (!pend && n_acc < 10000 && $urandom_range(0, 99) < 70) begin
        pend    = 1'b1;
        cur_e   = ($urandom_range(0, 7) == 0) ? 31'($urandom_range(0, 3)) : 31'($urandom());
        cur_tag = tag_ctr;
      end
      ordy = (n_acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_cycle(pend, cur_e, cur_tag, ordy);
      n_tests++; if (in_ready !== sb_rdy_exp) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=%b", in_ready, sb_rdy_exp); end
      if (sb_held_chk) begin
        n_tests++; if (sb_now_val !== sb_held_val) begin n_fail++; $display("FAIL bp_stable got=%h exp=%h", sb_now_val, sb_held_val); end
      end
      if (sb_unexp) begin n_tests++; n_fail++; $display("FAIL bp_unexpected f=%h tag=%h", f, out_tag); end
      if (sb_popped) begin
        pops++;
        n_tests++;
        if ({f, out_tag, out_zero} !== {sb_exp_f, sb_exp_tag, sb_exp_zero}) begin
          n_fail++; $display("FAIL bp_result got=%h/%h/%b exp=%h/%h/%b", f, out_tag, out_zero, sb_exp_f, sb_exp_tag, sb_exp_zero);
        end
      end
      if (pend && sb_rdy_exp) begin
        pend = 1'b0; n_acc++; tag_ctr = tag_ctr + 4'd1;
      end
    end
    n_tests++; if (pops !== 10000) begin n_fail++; $display("FAIL bp_count got=%0d exp=10000", pops); end
    drive_cycle(1'b0, 31'd0, 4'd0, 1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic got = 1'b0;
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 31'($urandom()), 4'(i), 1'b1);
    for (int i = 0; i < 9; i++) drive_cycle(1'b0, 31'd0, 4'd0, 1'b0);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_prefill got=%b exp=1", out_valid); end
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    n_tests++; if ({f, out_tag, out_zero} !== 22'd0) begin n_fail++; $display("FAIL rst_mid_outputs got=%h exp=0", {f, out_tag, out_zero}); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    exp_q.delete(); tag_q.delete(); zero_q.delete(); acc_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b0, 31'd0, 4'd0, 1'b1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale got=%b exp=0 f=%h", out_valid, f); end
    end
    drive_cycle(1'b1, 31'd2, 4'd5, 1'b1);
    for (int c = 0; c < 40 && !got; c++) begin
      drive_cycle(1'b0, 31'd0, 4'd0, 1'b1);
      if (sb_popped) begin
        got = 1'b1;
        n_tests++; if (f !== 17'd4) begin n_fail++; $display("FAIL rst_mid_f got=%h exp=4", f); end
        n_tests++; if (out_tag !== 4'd5) begin n_fail++; $display("FAIL rst_mid_tag got=%h exp=5", out_tag); end
        n_tests++; if (sb_lat !== 17) begin n_fail++; $display("FAIL rst_mid_latency got=%0d exp=17", sb_lat); end
      end
    end
    if (!got) begin n_tests++; n_fail++; $display("FAIL rst_mid_timeout got=no_result exp=result"); end
  endtask

  task automatic test_param_sweep();
    logic [3:0]  q8  [$];
    logic [7:0]  q16 [$];
    logic [19:0] q32 [$];
    int c8 [$], c16 [$], c32 [$];
    logic [31:0] r;
    int lat;
    for (int c = 0; c < 290; c++) begin
      @(negedge clk);
      if (s8_ov) begin
        n_tests++;
        if (q8.size() == 0) begin n_fail++; $display("FAIL sw8_unexpected f=%h", s8_f); end
        else begin
          lat = cyc - c8.pop_front();
          if (s8_f !== q8[0] || lat != 4) begin n_fail++; $display("FAIL sw8_result got=%h lat=%0d exp=%h lat=4", s8_f, lat, q8[0]); end
          void'(q8.pop_front());
        end
      end
      if (s16_ov) begin
        n_tests++;
        if (q16.size() == 0) begin n_fail++; $display("FAIL sw16_unexpected f=%h", s16_f); end
        else begin
          lat = cyc - c16.pop_front();
          if (s16_f !== q16[0] || lat != 8) begin n_fail++; $display("FAIL sw16_result got=%h lat=%0d exp=%h lat=8", s16_f, lat, q16[0]); end
          void'(q16.pop_front());
        end
      end
      if (s32_ov) begin
        n_tests++;
        if (q32.size() == 0) begin n_fail++; $display("FAIL sw32_unexpected f=%h", s32_f); end
        else begin
          lat = cyc - c32.pop_front();
          if (s32_f !== q32[0] || lat != 20) begin n_fail++; $display("FAIL sw32_result got=%h lat=%0d exp=%h lat=20", s32_f, lat, q32[0]); end
          void'(q32.pop_front());
        end
      end
      n_tests++; if ({s8_ir, s16_ir, s32_ir} !== 3'b111) begin n_fail++; $display("FAIL sw_in_ready got=%b exp=111", {s8_ir, s16_ir, s32_ir}); end
      if (c < 256) begin
        s8_v = 1'b1; s16_v = 1'b1; s32_v = 1'b1;
        s8_e  = 8'(c);
        s16_e = (c == 1) ? 16'hFFFF : 16'($urandom());
        s32_e = (c == 1) ? 32'hFFFF_FFFF : $urandom();
        r = isqrt({56'd0, s8_e});       q8.push_back(r[3:0]);   c8.push_back(cyc + 1);
        r = isqrt({48'd0, s16_e});      q16.push_back(r[7:0]);  c16.push_back(cyc + 1);
        r = isqrt({32'd0, s32_e} << 8); q32.push_back(r[19:0]); c32.push_back(cyc + 1);
      end else begin
        s8_v = 1'b0; s16_v = 1'b0; s32_v = 1'b0;
      end
    end
    n_tests++;
    if (q8.size() + q16.size() + q32.size() != 0) begin
      n_fail++; $display("FAIL sw_leftover got=%0d/%0d/%0d exp=0/0/0", q8.size(), q16.size(), q32.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
